// File: rtl/sa_delay_feeder.sv
// sa_delay_feeder: feeds delayed echo samples for one focal point into the
// channel summer. For each channel it reads the echo buffer at
// base_addr + delay[ch] and streams the result as sum_en/delayed_sample.
// The stream is framed by start_sum and done_channel. It then waits for the
// summer's valid before pulsing done.
// Optional build macro FEED_TIMEOUT_EN: bounds the wait for sum_valid to
// 16 cycles. On expiry it sets err_timeout and still completes.
module sa_delay_feeder #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 10,
  parameter int DELAY_WIDTH  = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic [NUM_CHANNELS*DELAY_WIDTH-1:0] delay_in,
  output logic                                mem_rd_en,
  output logic [$clog2(NUM_CHANNELS)-1:0]     mem_ch,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  input  logic [DATA_WIDTH-1:0]               mem_rdata,
  output logic                                start_sum,
  output logic                                sum_en,
  output logic [DATA_WIDTH-1:0]               delayed_sample,
  output logic                                done_channel,
  input  logic                                sum_valid,
  output logic                                busy,
  output logic                                done,
  output logic                                err_oob,
  output logic                                err_timeout
);

  localparam int CH_W = $clog2(NUM_CHANNELS);
  localparam int AW1  = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_READ, S_DRAIN, S_FLUSH, S_WAIT, S_FIN
  } state_t;

  state_t                              state_q, state_d;
  logic [CH_W-1:0]                     ch_q, ch_d;
  logic [ADDR_WIDTH-1:0]               base_q, base_d;
  logic [NUM_CHANNELS*DELAY_WIDTH-1:0] delay_q, delay_d;
  logic                                start_acc;

  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [CH_W-1:0]       mem_ch_q, mem_ch_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  rd_zero_q, rd_zero_d;   // slot issued this cycle is zero-substituted
  logic                  start_sum_q, start_sum_d;
  logic                  sum_en_q, sum_en_d;
  logic                  szero_q, szero_d;       // sample slot on the summer side is zero
  logic                  done_channel_q, done_channel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_oob_q, err_oob_d;

  logic [DELAY_WIDTH-1:0] dly_sel;
  logic [AW1-1:0]         addr_sum;
  logic                   issue;

`ifdef FEED_TIMEOUT_EN
  logic [4:0] tmo_q, tmo_d;
  logic       timed_out;
  logic       err_timeout_q, err_timeout_d;
`endif

  // FSM next state, channel counter and latching of the focal-point request
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    base_d    = base_q;
    delay_d   = delay_q;
    start_acc = 1'b0;
`ifdef FEED_TIMEOUT_EN
    timed_out = 1'b0;
    tmo_d     = (state_q == S_WAIT) ? tmo_q + 5'd1 : 5'd0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = base_addr;
          delay_d   = delay_in;
          ch_d      = '0;
          start_acc = 1'b1;
          state_d   = S_CLR;
        end
      end
      S_CLR: begin
        ch_d    = '0;
        state_d = S_READ;
      end
      S_READ: begin
        if (ch_q == CH_W'(NUM_CHANNELS - 1)) begin
          ch_d    = '0;
          state_d = S_DRAIN;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_FLUSH;
      S_FLUSH: state_d = S_WAIT;
      S_WAIT: begin
        if (sum_valid) begin
          state_d = S_FIN;
        end
`ifdef FEED_TIMEOUT_EN
        else if (tmo_q == 5'd15) begin
          timed_out = 1'b1;
          state_d   = S_FIN;
        end
`endif
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the state being entered, so each
  // strobe lines up with its state. The summer side runs one cycle behind
  // the reads because the echo buffer has one cycle of read latency.
  always_comb begin
    dly_sel  = delay_q[ch_d*DELAY_WIDTH +: DELAY_WIDTH];
    addr_sum = {1'b0, base_q} + AW1'(dly_sel);
    issue    = (state_d == S_READ);

    mem_rd_en_d    = issue && !addr_sum[ADDR_WIDTH];
    mem_ch_d       = mem_rd_en_d ? ch_d : '0;
    mem_addr_d     = mem_rd_en_d ? addr_sum[ADDR_WIDTH-1:0] : '0;
    rd_zero_d      = issue && addr_sum[ADDR_WIDTH];
    start_sum_d    = (state_d == S_CLR);
    sum_en_d       = (state_q == S_READ);
    szero_d        = (state_q == S_READ) && rd_zero_q;
    done_channel_d = (state_d == S_FLUSH);
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_FIN);
    err_oob_d      = start_acc ? 1'b0 : (err_oob_q | rd_zero_d);
`ifdef FEED_TIMEOUT_EN
    err_timeout_d  = start_acc ? 1'b0 : (err_timeout_q | timed_out);
`endif
  end

  // State and output registers; synchronous reset aborts any focal point
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ch_q           <= '0;
      base_q         <= '0;
      delay_q        <= '0;
      mem_rd_en_q    <= 1'b0;
      mem_ch_q       <= '0;
      mem_addr_q     <= '0;
      rd_zero_q      <= 1'b0;
      start_sum_q    <= 1'b0;
      sum_en_q       <= 1'b0;
      szero_q        <= 1'b0;
      done_channel_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_oob_q      <= 1'b0;
`ifdef FEED_TIMEOUT_EN
      tmo_q          <= 5'd0;
      err_timeout_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      base_q         <= base_d;
      delay_q        <= delay_d;
      mem_rd_en_q    <= mem_rd_en_d;
      mem_ch_q       <= mem_ch_d;
      mem_addr_q     <= mem_addr_d;
      rd_zero_q      <= rd_zero_d;
      start_sum_q    <= start_sum_d;
      sum_en_q       <= sum_en_d;
      szero_q        <= szero_d;
      done_channel_q <= done_channel_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_oob_q      <= err_oob_d;
`ifdef FEED_TIMEOUT_EN
      tmo_q          <= tmo_d;
      err_timeout_q  <= err_timeout_d;
`endif
    end
  end

  assign mem_rd_en    = mem_rd_en_q;
  assign mem_ch       = mem_ch_q;
  assign mem_addr     = mem_addr_q;
  assign start_sum    = start_sum_q;
  assign sum_en       = sum_en_q;
  assign done_channel = done_channel_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_oob      = err_oob_q;

  // The buffer's read data arrives in the cycle after the read strobe, which
  // is the slot's sum_en cycle. The data is therefore steered through a mux
  // selected by registered flags instead of being re-registered. Re-registering
  // would push the stream one cycle late.
  assign delayed_sample = (sum_en_q && !szero_q) ? mem_rdata : '0;

`ifdef FEED_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule
